inv_mix_columns_seq: RTL and testbench



---
 rtl/inv_mix_columns_seq_pkg.sv | 42 ++++
 rtl/inv_mix_columns_seq_column32.sv | 42 ++++
 rtl/inv_mix_columns_seq.sv | 109 ++++++++++
 tb/tb_inv_mix_columns_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared AES definitions for the iterative (Inv)MixColumns engine.
// Holds the GF(2^8) reduction constant, the column coefficients, the FSM
// state type, the state/column typedefs and the GF(2^8) multiply helpers.
// Optional feature macro used by the users of this package: INV_MIX_COLUMNS_FWD_EN.
package inv_mix_columns_seq_pkg;

    localparam logic [7:0] GF_RED    = 8'h1b;
    localparam logic [7:0] COEF_0E   = 8'h0e;
    localparam logic [7:0] COEF_0B   = 8'h0b;
    localparam logic [7:0] COEF_0D   = 8'h0d;
    localparam logic [7:0] COEF_09   = 8'h09;
    localparam logic [7:0] COEF_02   = 8'h02;
    localparam logic [7:0] COEF_03   = 8'h03;
    localparam logic [7:0] COEF_01   = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant k the unused branches fold away.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_columns_seq_column32.sv
// inv_mix_column32: combinational transform of one 32-bit AES column.
// Byte s0 (row 0) is the MSB byte. Default is InvMixColumns
// (0e/0b/0d/09 circulant); with INV_MIX_COLUMNS_FWD_EN defined, i_fwd=1
// selects forward MixColumns (02/03/01/01 in the same rotation).
// Ports:
//   i_col  [31:0]  input column
//   i_fwd          mode select (only with INV_MIX_COLUMNS_FWD_EN)
//   o_col  [31:0]  transformed column
module inv_mix_column32
    import inv_mix_columns_seq_pkg::*;
(
    input  logic [31:0] i_col,
`ifdef INV_MIX_COLUMNS_FWD_EN
    input  logic        i_fwd,
`endif
    output logic [31:0] o_col
);

    logic [7:0] w_s0, w_s1, w_s2, w_s3;
    logic [7:0] w_ka, w_kb, w_kc, w_kd;

    assign {w_s0, w_s1, w_s2, w_s3} = i_col;

    // w_ka..w_kd are the coefficients in the 0e/0b/0d/09 slots of row 0.
`ifdef INV_MIX_COLUMNS_FWD_EN
    assign w_ka = i_fwd ? COEF_02 : COEF_0E;
    assign w_kb = i_fwd ? COEF_03 : COEF_0B;
    assign w_kc = i_fwd ? COEF_01 : COEF_0D;
    assign w_kd = i_fwd ? COEF_01 : COEF_09;
`else
    assign w_ka = COEF_0E;
    assign w_kb = COEF_0B;
    assign w_kc = COEF_0D;
    assign w_kd = COEF_09;
`endif

    assign o_col[31:24] = gf_mul(w_s0, w_ka) ^ gf_mul(w_s1, w_kb) ^ gf_mul(w_s2, w_kc) ^ gf_mul(w_s3, w_kd);
    assign o_col[23:16] = gf_mul(w_s0, w_kd) ^ gf_mul(w_s1, w_ka) ^ gf_mul(w_s2, w_kb) ^ gf_mul(w_s3, w_kc);
    assign o_col[15:8]  = gf_mul(w_s0, w_kc) ^ gf_mul(w_s1, w_kd) ^ gf_mul(w_s2, w_ka) ^ gf_mul(w_s3, w_kb);
    assign o_col[7:0]   = gf_mul(w_s0, w_kb) ^ gf_mul(w_s1, w_kc) ^ gf_mul(w_s2, w_kd) ^ gf_mul(w_s3, w_ka);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: iterative AES InvMixColumns engine. Accepts a
// 128-bit state on a valid/ready handshake, transforms one column per
// clock through a single shared column datapath, and presents the result
// on a second valid/ready handshake.
// Optional feature: INV_MIX_COLUMNS_FWD_EN adds the fwd input, captured
// with data_in, which selects forward MixColumns for that operation.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   input handshake, data_in[127:0] (column c at [127-32c -: 32])
//   fwd              forward-mode select (only with INV_MIX_COLUMNS_FWD_EN)
//   out_valid/ready  output handshake, data_out[127:0]
//
// state | meaning
// IDLE  | waiting for an input state, in_ready=1
// BUSY  | transforming column r_col_cnt, one column per cycle
// DONE  | result held on data_out with out_valid=1
module inv_mix_columns_seq
    import inv_mix_columns_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
`ifdef INV_MIX_COLUMNS_FWD_EN
    input  logic         fwd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_col_cnt;
    aes_state_t r_work;
    aes_col_t   w_col_in;
    aes_col_t   w_col_out;
    logic       w_load;
`ifdef INV_MIX_COLUMNS_FWD_EN
    logic       r_fwd;
`endif

    // A DONE-state handshake can hand straight over to a new input.
    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign out_valid = (r_state == DONE);
    assign data_out  = r_work;
    assign w_load    = in_valid && in_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = BUSY;
            BUSY:    if (r_col_cnt == 2'd3) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = in_valid ? BUSY : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_col_in = r_work[127:96];
        case (r_col_cnt)
            2'd0: w_col_in = r_work[127:96];
            2'd1: w_col_in = r_work[95:64];
            2'd2: w_col_in = r_work[63:32];
            2'd3: w_col_in = r_work[31:0];
            default: w_col_in = r_work[127:96];
        endcase
    end

    inv_mix_column32 u_col (
        .i_col (w_col_in),
`ifdef INV_MIX_COLUMNS_FWD_EN
        .i_fwd (r_fwd),
`endif
        .o_col (w_col_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_col_cnt <= 2'd0;
            r_work    <= '0;
`ifdef INV_MIX_COLUMNS_FWD_EN
            r_fwd     <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_work    <= data_in;
                r_col_cnt <= 2'd0;
`ifdef INV_MIX_COLUMNS_FWD_EN
                r_fwd     <= fwd;
`endif
            end else if (r_state == BUSY) begin
                // Counter wraps 3->0 as the FSM leaves BUSY.
                r_col_cnt <= r_col_cnt + 2'd1;
                case (r_col_cnt)
                    2'd0: r_work[127:96] <= w_col_out;
                    2'd1: r_work[95:64]  <= w_col_out;
                    2'd2: r_work[63:32]  <= w_col_out;
                    2'd3: r_work[31:0]   <= w_col_out;
                    default: r_work[127:96] <= w_col_out;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
`ifdef INV_MIX_COLUMNS_FWD_EN
    logic         fwd;
`endif

    int tests;
    int failed;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
`ifdef INV_MIX_COLUMNS_FWD_EN
        .fwd       (fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product per column: M[r][j] = coef[(j - r) mod 4].
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic use_fwd);
        logic [7:0]   coef [4];
        logic [127:0] res;
        logic [7:0]   acc;
        if (use_fwd) begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end else begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ ref_gmul(s[127 - 32*c - 8*j -: 8], coef[(j - r + 4) % 4]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [127:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        data_in  = d;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("send_timeout", 128'(n), 128'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = rnd128();
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!out_valid && cnt < 50);
        if (!out_valid) check("out_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consumed_valid_low", 128'(out_valid), 128'd0);
    endtask

    task automatic run_check(input string tag, input logic [127:0] d, input logic [127:0] exp);
        int cnt;
        send(d);
        wait_out(cnt);
        check({tag, "_lat"}, 128'(cnt), 128'd4);
        check(tag, data_out, exp);
        consume();
    endtask

    initial begin
        int cnt;
        logic [127:0] a, b, c, held;
        tests = 0; failed = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
`ifdef INV_MIX_COLUMNS_FWD_EN
        fwd = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_data_out", data_out, 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // Known vector, out_ready held high.
        out_ready = 1'b1;
        send(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);
        wait_out(cnt);
        check("known_lat", 128'(cnt), 128'd4);
        check("known_data", data_out, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
        @(posedge clk); #1;
        check("known_valid_drop", 128'(out_valid), 128'd0);
        check("known_idle_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b0;

        run_check("fixed_01", {16{8'h01}}, {16{8'h01}});
        run_check("fixed_c6", {16{8'hc6}}, {16{8'hc6}});

        for (int i = 0; i < 6; i++) begin
            a = rnd128();
            run_check("random", a, ref_mix(a, 1'b0));
        end

        // Backpressure then back-to-back handover.
        a = rnd128();
        b = rnd128();
        send(a);
        wait_out(cnt);
        held = data_out;
        check("bp_data", held, ref_mix(a, 1'b0));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_stable", data_out, held);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        check("bp_valid_held", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = b;
        #1;
        check("b2b_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = rnd128();
        check("b2b_valid_drop", 128'(out_valid), 128'd0);
        wait_out(cnt);
        check("b2b_lat", 128'(cnt), 128'd4);
        check("b2b_data", data_out, ref_mix(b, 1'b0));
        consume();

        // Inputs wiggling while busy must be ignored.
        c = rnd128();
        send(c);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            data_in  = rnd128();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_out(cnt);
        check("busy_ign_lat", 128'(cnt), 128'd1);
        check("busy_ign_data", data_out, ref_mix(c, 1'b0));
        consume();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        check("no_extra_out", 128'(cnt), 128'd0);

        // Reset in the middle of BUSY.
        send(rnd128());
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 128'(out_valid), 128'd0);
        check("midrst_data", data_out, 128'd0);
        check("midrst_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        a = rnd128();
        run_check("post_rst", a, ref_mix(a, 1'b0));

`ifdef INV_MIX_COLUMNS_FWD_EN
        fwd = 1'b1;
        run_check("fwd_known", {4{32'hdb135345}}, {4{32'h8e4da1bc}});
        a = rnd128();
        run_check("fwd_random", a, ref_mix(a, 1'b1));
        fwd = 1'b0;
        run_check("fwd_back_inv", {4{32'h8e4da1bc}}, {4{32'hdb135345}});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
